// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, with a single outstanding miss.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_addr_out,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_ready,
    input  logic [31:0] mc_instr,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } state_e;

    // Handshakes: fetcher holds fetch_req/fetch_addr until a one-cycle fetch_valid pulse;
    // mc_req/mc_addr stay stable until the memory controller pulses mc_ready.
    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic               fetch_valid_q, fetch_valid_d;
    logic [31:0]        fetch_instr_q, fetch_instr_d;
    logic [31:0]        fetch_addr_out_q, fetch_addr_out_d;
    logic               mc_req_q, mc_req_d;
    logic [31:0]        mc_addr_q, mc_addr_d;
`ifdef ICACHE_PERF_EN
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;
`endif

    logic [INDEX_BITS-1:0] fetch_idx, fill_idx;
    logic [TAG_W-1:0]      fetch_tag, fill_tag;
    logic                  lookup_hit;
    logic                  fill_we;

    assign fetch_idx  = fetch_addr[INDEX_BITS+1:2];
    assign fetch_tag  = fetch_addr[31:INDEX_BITS+2];
    assign fill_idx   = mc_addr_q[INDEX_BITS+1:2];
    assign fill_tag   = mc_addr_q[31:INDEX_BITS+2];
    assign lookup_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        fetch_valid_d    = 1'b0;
        fetch_instr_d    = fetch_instr_q;
        fetch_addr_out_d = fetch_addr_out_q;
        mc_req_d         = mc_req_q;
        mc_addr_d        = mc_addr_q;
        fill_we          = 1'b0;
`ifdef ICACHE_PERF_EN
        hit_cnt_d        = hit_cnt_q;
        miss_cnt_d       = miss_cnt_q;
`endif
        if (rob_clear) begin
            // Flush wins over a same-cycle fill: the pending miss is dropped outright.
            state_d  = IDLE;
            mc_req_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_req && !fetch_valid_q) begin
                        if (lookup_hit) begin
                            fetch_valid_d    = 1'b1;
                            fetch_instr_d    = data_q[fetch_idx];
                            fetch_addr_out_d = fetch_addr;
`ifdef ICACHE_PERF_EN
                            hit_cnt_d        = hit_cnt_q + 32'd1;
`endif
                        end else begin
                            state_d   = MISS;
                            mc_req_d  = 1'b1;
                            mc_addr_d = fetch_addr;
`ifdef ICACHE_PERF_EN
                            miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                        end
                    end
                end
                MISS: begin
                    if (mc_ready) begin
                        fill_we            = 1'b1;
                        valid_d[fill_idx]  = 1'b1;
                        state_d            = RESP;
                        mc_req_d           = 1'b0;
                        fetch_valid_d      = 1'b1;
                        fetch_instr_d      = mc_instr;
                        fetch_addr_out_d   = mc_addr_q;
                    end
                end
                RESP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            valid_q          <= '0;
            fetch_valid_q    <= 1'b0;
            fetch_instr_q    <= '0;
            fetch_addr_out_q <= '0;
            mc_req_q         <= 1'b0;
            mc_addr_q        <= '0;
`ifdef ICACHE_PERF_EN
            hit_cnt_q        <= '0;
            miss_cnt_q       <= '0;
`endif
        end else if (rdy) begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            fetch_valid_q    <= fetch_valid_d;
            fetch_instr_q    <= fetch_instr_d;
            fetch_addr_out_q <= fetch_addr_out_d;
            mc_req_q         <= mc_req_d;
            mc_addr_q        <= mc_addr_d;
`ifdef ICACHE_PERF_EN
            hit_cnt_q        <= hit_cnt_d;
            miss_cnt_q       <= miss_cnt_d;
`endif
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify a line.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mc_instr;
        end
    end

    assign fetch_valid    = fetch_valid_q;
    assign fetch_instr    = fetch_instr_q;
    assign fetch_addr_out = fetch_addr_out_q;
    assign mc_req         = mc_req_q;
    assign mc_addr        = mc_addr_q;
`ifdef ICACHE_PERF_EN
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;
`endif
    assign dbg_state_o    = state_q;

endmodule
